// File: rtl/uart16550_axil_tx_if.sv
// rtl/uart16550_axil_tx_if.sv - TX FIFO pop handshake between FIFO and transmit shifter
//
// Purpose: groups the TX FIFO head/empty/pop signals into one bundle.
// Signals:
//   fifo_odata  [7:0]  head byte of the TX FIFO, valid while fifo_empty=0
//   fifo_empty         FIFO holds no byte
//   fifo_read          one-cycle pop strobe from the shifter
// Modports:
//   master  transmit shifter side (consumes bytes, issues pops)
//   slave   FIFO side (presents head byte, accepts pops)

interface uart16550_axil_tx_if;
  logic [7:0] fifo_odata;
  logic       fifo_empty;
  logic       fifo_read;

  modport master (input fifo_odata, input fifo_empty, output fifo_read);
  modport slave  (output fifo_odata, output fifo_empty, input fifo_read);
endinterface

// File: rtl/uart16550_axil_tx.sv
// rtl/uart16550_axil_tx.sv - 16550-style UART transmit shifter with FIFO pop and break
//
// Purpose: serialises bytes from the TX FIFO as start / 5..8 data bits (LSB first) /
// optional parity / 1, 1.5 or 2 stop bits, at 16 baud_ticks per bit.
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   synchronous active-low reset
//   baud_tick  in   16x oversample enable, one clk wide
//   fifo       if   TX FIFO handshake (master modport: odata/empty in, read out)
//   wls        in   word length select 00=5 .. 11=8 bits
//   stb        in   stop bits: 0=1, 1=1.5 (wls=00) or 2
//   pen/eps/sp in   parity enable / even parity / stick parity
//   set_break  in   force txd low
//   txd        out  serial line, idle high
//   tx_idle    out  high while the shifter is idle

module uart16550_axil_tx (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                baud_tick,
  uart16550_axil_tx_if.master fifo,
  input  logic [1:0]          wls,
  input  logic                stb,
  input  logic                pen,
  input  logic                eps,
  input  logic                sp,
  input  logic                set_break,
  output logic                txd,
  output logic                tx_idle
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] wls_q, wls_d;
  logic       stb_q, stb_d;
  logic       pen_q, pen_d;
  logic       par_q, par_d;
  logic       txd_q, read_q, idle_q;
  logic       line_d, load;
  logic       tick_end, stop_end;
  logic [7:0] data_m;
  logic       par_new;

  assign tick_end = baud_tick && (tick_q == 4'hF);

  // Parity is resolved at load time from the live config, so eps/sp need no
  // storage of their own; only the word-length-masked data takes part.
  assign data_m  = fifo.fifo_odata & (8'hFF >> (2'd3 - wls));
  assign par_new = sp ? ~eps : (eps ? ^data_m : ~(^data_m));

  // Stop phase: bit_q counts completed stop bit periods. The half bit of the
  // 1.5-stop case ends after 8 ticks of the second period.
  assign stop_end = baud_tick &&
                    (stb_q ? ((bit_q == 3'd1) &&
                              (tick_q == ((wls_q == 2'b00) ? 4'd7 : 4'd15)))
                           : (tick_q == 4'hF));

  always_comb begin
    state_d = state_q;
    tick_d  = baud_tick ? tick_q + 4'd1 : tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wls_d   = wls_q;
    stb_d   = stb_q;
    pen_d   = pen_q;
    par_d   = par_q;
    load    = 1'b0;
    line_d  = 1'b1;

    case (state_q)
      S_IDLE: begin
        tick_d = 4'd0;
        load   = !fifo.fifo_empty;
      end
      S_START: begin
        if (tick_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (tick_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == ({1'b0, wls_q} + 3'd4)) begin
            state_d = pen_q ? S_PARITY : S_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick_end) begin
          state_d = S_STOP;
          bit_d   = 3'd0;
        end
      end
      S_STOP: begin
        if (stop_end) begin
          tick_d = 4'd0;
          bit_d  = 3'd0;
          if (!fifo.fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tick_end) begin
          bit_d = 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = 4'd0;
        bit_d   = 3'd0;
      end
    endcase

    // A load overrides everything above; a tick in this cycle is discarded.
    if (load) begin
      state_d = S_START;
      tick_d  = 4'd0;
      bit_d   = 3'd0;
      shift_d = fifo.fifo_odata;
      wls_d   = wls;
      stb_d   = stb;
      pen_d   = pen;
      par_d   = par_new;
    end

    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      wls_q   <= 2'd0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      read_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wls_q   <= wls_d;
      stb_q   <= stb_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      txd_q   <= set_break ? 1'b0 : line_d;
      read_q  <= load;
      idle_q  <= (state_d == S_IDLE);
    end
  end

  assign txd            = txd_q;
  assign tx_idle        = idle_q;
  assign fifo.fifo_read = read_q;

endmodule

// File: tb/tb_uart16550_axil_tx.sv
// tb/tb_uart16550_axil_tx.sv - self-checking bench for uart16550_axil_tx

module tb_uart16550_axil_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud_tick;
  logic [1:0] wls;
  logic       stb, pen, eps, sp, set_break;
  logic       txd, tx_idle;

  uart16550_axil_tx_if bus();

  uart16550_axil_tx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_tick (baud_tick),
    .fifo      (bus),
    .wls       (wls),
    .stb       (stb),
    .pen       (pen),
    .eps       (eps),
    .sp        (sp),
    .set_break (set_break),
    .txd       (txd),
    .tx_idle   (tx_idle)
  );

  always #5 clk = ~clk;

  // Baud tick every 4 clocks, driven just after the rising edge.
  int tick_div = 0;
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_div  = (tick_div == 3) ? 0 : tick_div + 1;
      baud_tick = (tick_div == 3);
    end
  end

  // FIFO model: the test writes mem/wr_ptr, the monitor below owns rd_ptr.
  logic [7:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_empty_err = 0;
  int rd_dbl = 0;
  int busy_ticks = 0;
  logic rd_prev = 1'b0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_odata = fmem[rd_ptr[5:0]];

  always @(negedge clk) begin
    if (bus.fifo_read === 1'b1) begin
      if (rd_ptr == wr_ptr) rd_empty_err <= rd_empty_err + 1;
      else                  rd_ptr <= rd_ptr + 1;
      if (rd_prev) rd_dbl <= rd_dbl + 1;
    end
    rd_prev <= (bus.fifo_read === 1'b1);
    if (baud_tick && (tx_idle === 1'b0)) busy_ticks <= busy_ticks + 1;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         nbits;
    bit         pen;
    bit         par;
    int         stop_ticks;
  } frame_t;

  frame_t exp_q[$];
  int     frame_no = 0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] wls;
    logic       stb, pen, eps, sp;
    bit         exp_par;
    int         exp_stop;
  } vec_t;

  vec_t tbl [7];

  task automatic push_byte(input logic [7:0] b);
    fmem[wr_ptr[5:0]] = b;
    wr_ptr++;
  endtask

  task automatic push_exp(input logic [7:0] d, input int nbits, input bit p,
                          input bit par, input int stop_ticks);
    frame_t f;
    f.data = d; f.nbits = nbits; f.pen = p; f.par = par; f.stop_ticks = stop_ticks;
    exp_q.push_back(f);
  endtask

  task automatic wait_read(input string name);
    int g = 0;
    while (bus.fifo_read !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk({name, "_pop"}, int'(bus.fifo_read === 1'b1), 1);
    chk({name, "_tx_idle_low"}, int'(tx_idle === 1'b1), 0);
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (tx_idle !== 1'b1 && g < 4000) begin
      @(negedge clk);
      g++;
    end
    chk({name, "_idle"}, int'(tx_idle === 1'b1), 1);
  endtask

  task automatic wait_busy(input int snap, input int n);
    int g = 0;
    while ((busy_ticks - snap) < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
  endtask

  // Checks txd on every cycle of each expected segment; segment lengths are
  // counted in baud ticks. gap = negedges waited before the start bit appeared.
  task automatic check_frame(output int gap);
    frame_t f;
    logic   lvl [12];
    int     len [12];
    int     nseg, bad, cnt, guard;
    bit     first;
    gap = 0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 1, 0);
      return;
    end
    f = exp_q.pop_front();
    frame_no++;
    nseg = 0;
    lvl[nseg] = 1'b0; len[nseg] = 16; nseg++;
    for (int i = 0; i < f.nbits; i++) begin
      lvl[nseg] = f.data[i]; len[nseg] = 16; nseg++;
    end
    if (f.pen) begin
      lvl[nseg] = f.par; len[nseg] = 16; nseg++;
    end
    lvl[nseg] = 1'b1; len[nseg] = f.stop_ticks; nseg++;

    while (txd !== 1'b0 && gap < 5000) begin
      @(negedge clk);
      gap++;
    end
    chk($sformatf("frame%0d_start_seen", frame_no), int'(txd === 1'b0), 1);
    if (txd !== 1'b0) return;

    first = 1'b1;
    for (int s = 0; s < nseg; s++) begin
      bad = 0; cnt = 0; guard = 0;
      while (cnt < len[s] && guard < 2000) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        guard++;
        if (txd !== lvl[s]) bad++;
        if (baud_tick) cnt++;
      end
      if (cnt < len[s]) bad++;
      chk($sformatf("frame%0d_seg%0d_lvl%0d", frame_no, s, int'(lvl[s])), bad, 0);
    end
  endtask

  initial begin
    int gap, gap2, gap3, snap, r0, bad, nb;

    tbl[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16};
    tbl[1] = '{8'h03, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24};
    tbl[2] = '{8'h5A, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32};
    tbl[3] = '{8'h3F, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16};
    tbl[4] = '{8'hFF, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32};
    tbl[5] = '{8'hE0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16};
    tbl[6] = '{8'h81, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24};

    reset_n = 1'b0; wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    set_break = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_txd", int'(txd === 1'b1), 1);
    chk("reset_tx_idle", int'(tx_idle === 1'b1), 1);
    chk("reset_fifo_read", int'(bus.fifo_read === 1'b1), 0);
    reset_n = 1'b1;

    // Empty FIFO for 1000 ticks: line idle, no pops.
    bad = 0;
    repeat (4000) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_idle !== 1'b1 || bus.fifo_read !== 1'b0) bad++;
    end
    chk("empty_idle_cycles_bad", bad, 0);
    chk("empty_pops", rd_ptr, 0);

    // Table vectors; config is scrambled once the frame has started.
    for (int i = 0; i < 7; i++) begin
      wls = tbl[i].wls; stb = tbl[i].stb; pen = tbl[i].pen;
      eps = tbl[i].eps; sp = tbl[i].sp;
      nb = int'(tbl[i].wls) + 5;
      push_exp(tbl[i].data, nb, tbl[i].pen, tbl[i].exp_par, tbl[i].exp_stop);
      snap = busy_ticks;
      r0 = rd_ptr;
      push_byte(tbl[i].data);
      wait_read($sformatf("v%0d", i));
      wls = ~wls; stb = ~stb; pen = ~pen; eps = ~eps; sp = ~sp;
      check_frame(gap);
      wait_idle($sformatf("v%0d", i));
      chk($sformatf("v%0d_busy_ticks", i), busy_ticks - snap,
          16 * (1 + nb + int'(tbl[i].pen)) + tbl[i].exp_stop);
      chk($sformatf("v%0d_pops", i), rd_ptr - r0, 1);
    end

    // Three queued bytes, stick parity (1), back-to-back frames.
    wls = 2'b11; stb = 1'b0; pen = 1'b1; eps = 1'b0; sp = 1'b1;
    push_exp(8'h11, 8, 1'b1, 1'b1, 16);
    push_exp(8'h22, 8, 1'b1, 1'b1, 16);
    push_exp(8'h33, 8, 1'b1, 1'b1, 16);
    r0 = rd_ptr;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    wait_read("b2b");
    check_frame(gap);
    check_frame(gap2);
    check_frame(gap3);
    chk("b2b_gap2", gap2, 1);
    chk("b2b_gap3", gap3, 1);
    wait_idle("b2b");
    chk("b2b_pops", rd_ptr - r0, 3);

    // Break pulse during data of 8'hFF.
    wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    snap = busy_ticks;
    push_byte(8'hFF);
    wait_read("brk");
    wait_busy(snap, 53);
    set_break = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b0) bad++;
    end
    chk("brk_low_cycles_bad", bad, 0);
    set_break = 1'b0;
    @(negedge clk);
    chk("brk_release_txd", int'(txd === 1'b1), 1);
    wait_idle("brk");
    chk("brk_busy_ticks", busy_ticks - snap, 160);

    // Reset at data bit 3; the queued next byte waits for reset release.
    r0 = rd_ptr;
    snap = busy_ticks;
    push_byte(8'h55);
    push_exp(8'h96, 8, 1'b0, 1'b0, 16);
    push_byte(8'h96);
    wait_read("rst");
    wait_busy(snap, 69);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_txd", int'(txd === 1'b1), 1);
    chk("rst_tx_idle", int'(tx_idle === 1'b1), 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.fifo_read !== 1'b0 || txd !== 1'b1) bad++;
    end
    chk("rst_hold_bad", bad, 0);
    chk("rst_pops_during", rd_ptr - r0, 1);
    reset_n = 1'b1;
    wait_read("rst_next");
    check_frame(gap);
    wait_idle("rst_next");
    chk("rst_pops_after", rd_ptr - r0, 2);

    chk("pop_while_empty", rd_empty_err, 0);
    chk("pop_longer_than_1", rd_dbl, 0);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
